// File: rtl/branch_update_unit.sv
// ---------------------------------------------------------------------------
// branch_update_unit
//
// Resolves executed branches against the fetch-time prediction, raises a
// one-cycle redirect pulse on a mispredict, and keeps the 4-entry BTB trained
// through a small update queue. The queue drains one BTB write per cycle.
//
// Build option:
//   BP_HYSTERESIS_EN  defined   : per-index 2-bit saturating direction counters
//                                 decide the written active bit.
//                     undefined : no counters; active bit = last outcome.
//
// Parameters:
//   DEPTH            update-queue entries (power of two, >= 2)
//
// Ports:
//   CLK              clock, rising edge
//   nRST             synchronous active-low reset
//   resolve_valid    resolved branch presented this cycle
//   resolve_pc       branch PC (hash = [3:2], tag = [31:4])
//   resolve_taken    actual direction
//   resolve_target   actual taken target
//   pred_hit         fetch predicted taken (BTB hit)
//   pred_target      word target fetch used on a hit
//   hold             stalls queue drain
//   full             queue holds DEPTH entries
//   overflow         sticky: resolve arrived while full
//   mispredict       registered redirect pulse
//   correct_pc       redirect PC, valid with mispredict
//   wen              BTB write enable (registered)
//   hash_wsel        BTB index
//   tag_n            BTB tag
//   target_n         BTB word target
//   active_n         BTB entry valid bit
// ---------------------------------------------------------------------------
module branch_update_unit #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        pred_hit,
    input  logic [29:0] pred_target,
    input  logic        hold,
    output logic        full,
    output logic        overflow,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    output logic        wen,
    output logic [1:0]  hash_wsel,
    output logic [27:0] tag_n,
    output logic [29:0] target_n,
    output logic        active_n
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Queue storage (payload is not reset; occupancy alone defines validity)
    logic [1:0]  qhash_q   [DEPTH];
    logic [27:0] qtag_q    [DEPTH];
    logic [29:0] qtarget_q [DEPTH];
    logic        qactive_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        overflow_q, overflow_d;
    logic        mispredict_q, mispredict_d;
    logic [31:0] correct_pc_q, correct_pc_d;
    logic        wen_q, wen_d;
    logic [1:0]  hash_q, hash_d;
    logic [27:0] tag_q, tag_d;
    logic [29:0] target_q, target_d;
    logic        active_q, active_d;

    // Resolve fields
    logic [1:0]  r_idx;
    logic [27:0] r_tag;
    logic [29:0] r_tgt;
    logic        r_mis;
    logic [31:0] r_cpc;
    logic        r_active;
    logic        r_needed;

    logic full_w, empty_w, accept, enq, deq, bypass, push;

    // Low address bits carry no information for word-aligned targets
    logic unused_lowbits;
    assign unused_lowbits = ^{resolve_pc[1:0], resolve_target[1:0]};

    assign r_idx = resolve_pc[3:2];
    assign r_tag = resolve_pc[31:4];
    assign r_tgt = resolve_target[31:2];

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    assign accept  = resolve_valid && !full_w;

    // Mispredict is judged on every presented resolve, accepted or not
    assign r_mis = resolve_valid &&
                   ((resolve_taken != pred_hit) ||
                    (resolve_taken && pred_hit && (r_tgt != pred_target)));
    assign r_cpc = resolve_taken ? {r_tgt, 2'b00}
                                 : ({resolve_pc[31:2], 2'b00} + 32'd4);

`ifdef BP_HYSTERESIS_EN
    logic [1:0] ctr_q [4];
    logic [1:0] ctr_d [4];
    logic [1:0] ctr_cur, ctr_new;

    assign ctr_cur = ctr_q[r_idx];

    always_comb begin
        ctr_new = ctr_cur;
        if (resolve_taken) begin
            if (ctr_cur != 2'b11) ctr_new = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_new = ctr_cur - 2'd1;
        end
    end

    assign r_active = ctr_new[1];

    always_comb begin
        for (int i = 0; i < 4; i++) ctr_d[i] = ctr_q[i];
        if (accept) ctr_d[r_idx] = ctr_new;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < 4; i++) ctr_q[i] <= 2'b01;
        end else begin
            for (int i = 0; i < 4; i++) ctr_q[i] <= ctr_d[i];
        end
    end
`else
    assign r_active = resolve_taken;
`endif

    // Only write the BTB when its contents would actually change behaviour
    assign r_needed = (r_active != pred_hit) ||
                      (r_active && (r_tgt != pred_target));
    assign enq      = accept && r_needed;

    // Empty queue forwards the incoming update straight to the write port so
    // the BTB sees it one cycle after accept.
    assign deq    = !empty_w && !hold;
    assign bypass = empty_w && enq && !hold;
    assign push   = enq && !bypass;

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q | (resolve_valid & full_w);
        mispredict_d = r_mis;
        correct_pc_d = r_mis ? r_cpc : correct_pc_q;
        wen_d        = deq || bypass;
        hash_d       = hash_q;
        tag_d        = tag_q;
        target_d     = target_q;
        active_d     = active_q;

        if (push) wptr_d = wptr_q + PW'(1);
        if (deq)  rptr_d = rptr_q + PW'(1);
        if (push && !deq)      count_d = count_q + CW'(1);
        else if (!push && deq) count_d = count_q - CW'(1);

        if (deq) begin
            hash_d   = qhash_q[rptr_q];
            tag_d    = qtag_q[rptr_q];
            target_d = qtarget_q[rptr_q];
            active_d = qactive_q[rptr_q];
        end else if (bypass) begin
            hash_d   = r_idx;
            tag_d    = r_tag;
            target_d = r_tgt;
            active_d = r_active;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            qhash_q[wptr_q]   <= r_idx;
            qtag_q[wptr_q]    <= r_tag;
            qtarget_q[wptr_q] <= r_tgt;
            qactive_q[wptr_q] <= r_active;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            mispredict_q <= 1'b0;
            correct_pc_q <= '0;
            wen_q        <= 1'b0;
            hash_q       <= '0;
            tag_q        <= '0;
            target_q     <= '0;
            active_q     <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            mispredict_q <= mispredict_d;
            correct_pc_q <= correct_pc_d;
            wen_q        <= wen_d;
            hash_q       <= hash_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            active_q     <= active_d;
        end
    end

    assign full       = full_w;
    assign overflow   = overflow_q;
    assign mispredict = mispredict_q;
    assign correct_pc = correct_pc_q;
    assign wen        = wen_q;
    assign hash_wsel  = hash_q;
    assign tag_n      = tag_q;
    assign target_n   = target_q;
    assign active_n   = active_q;

endmodule

// File: tb/tb_branch_update_unit.sv
module tb_branch_update_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        pred_hit;
    logic [29:0] pred_target;
    logic        hold;
    logic        full, overflow, mispredict, wen, active_n;
    logic [31:0] correct_pc;
    logic [1:0]  hash_wsel;
    logic [27:0] tag_n;
    logic [29:0] target_n;

    int checks = 0;
    int errors = 0;

    branch_update_unit #(.DEPTH(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .pred_hit(pred_hit), .pred_target(pred_target), .hold(hold),
        .full(full), .overflow(overflow), .mispredict(mispredict),
        .correct_pc(correct_pc), .wen(wen), .hash_wsel(hash_wsel),
        .tag_n(tag_n), .target_n(target_n), .active_n(active_n)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic        v;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        hit;
        logic [29:0] pt;
        logic        hold;
        logic        e_mis;
        logic [31:0] e_cpc;
        logic        e_wen;
        logic [1:0]  e_hash;
        logic [27:0] e_tag;
        logic [29:0] e_tgt;
        logic        e_act;
        logic        e_full;
        logic        e_ov;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(
        input logic rst_n, input logic v, input logic [31:0] pc, input logic tk,
        input logic [31:0] tgt, input logic hit, input logic [29:0] pt, input logic hd,
        input logic e_mis, input logic [31:0] e_cpc, input logic e_wen,
        input logic [1:0] e_hash, input logic [27:0] e_tag, input logic [29:0] e_tgt,
        input logic e_act, input logic e_full, input logic e_ov);
        vec_t r;
        r.rst_n = rst_n; r.v = v; r.pc = pc; r.tk = tk; r.tgt = tgt;
        r.hit = hit; r.pt = pt; r.hold = hd;
        r.e_mis = e_mis; r.e_cpc = e_cpc; r.e_wen = e_wen; r.e_hash = e_hash;
        r.e_tag = e_tag; r.e_tgt = e_tgt; r.e_act = e_act;
        r.e_full = e_full; r.e_ov = e_ov;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", row, name, act, expv);
        end
    endtask

    initial begin
        // reset / idle rows
        vec_t rst_row, idle;
        rst_row = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);

        tbl.push_back(rst_row);
        tbl.push_back(rst_row);
        // first training write, bypassed straight to the port
        tbl.push_back(mk(1,1,32'h104,1,32'h200,0,0,0, 1,32'h200,1,1,28'h10,30'h80,1,0,0));
        // correctly predicted, nothing to write
        tbl.push_back(mk(1,1,32'h104,1,32'h200,1,30'h80,0, 0,0,0,0,0,0,0,0,0));
`ifdef BP_HYSTERESIS_EN
        tbl.push_back(mk(1,1,32'h104,0,32'h200,1,30'h80,0, 1,32'h108,0,0,0,0,0,0,0));
`else
        tbl.push_back(mk(1,1,32'h104,0,32'h200,1,30'h80,0, 1,32'h108,1,1,28'h10,30'h80,0,0,0));
`endif
        tbl.push_back(mk(1,1,32'h104,0,32'h200,1,30'h80,0, 1,32'h108,1,1,28'h10,30'h80,0,0,0));
        idle = mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
        tbl.push_back(idle);
        // hold: fill, then overflow
        tbl.push_back(mk(1,1,32'h1008,1,32'h3000,0,0,1, 1,32'h3000,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'h200C,1,32'h4000,0,0,1, 1,32'h4000,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,1,32'h0,1,32'h5000,0,0,1, 1,32'h5000,0,0,0,0,0,1,1));
        // release: two writes in FIFO order
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,1,2,28'h100,30'hC00,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,1,3,28'h200,30'h1000,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
        // full with hold=0: dequeue only, resolve dropped
        tbl.push_back(mk(1,1,32'h1008,1,32'h3000,0,0,1, 1,32'h3000,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,1,32'h200C,1,32'h4000,0,0,1, 1,32'h4000,0,0,0,0,0,1,1));
        tbl.push_back(mk(1,1,32'h0004,1,32'h6000,0,0,0, 1,32'h6000,1,2,28'h100,30'hC00,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,1,3,28'h200,30'h1000,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
        // simultaneous enqueue and dequeue
        tbl.push_back(mk(1,1,32'h1008,1,32'h3000,0,0,1, 1,32'h3000,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,1,32'h200C,1,32'h4000,0,0,0, 1,32'h4000,1,2,28'h100,30'hC00,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,1,3,28'h200,30'h1000,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
        // taken-taken with wrong target
        tbl.push_back(mk(1,1,32'h1008,1,32'h7000,1,30'hC00,0, 1,32'h7000,1,2,28'h100,30'h1C00,1,0,1));
        // reset with two queued entries
        tbl.push_back(mk(1,1,32'h1008,1,32'h3000,0,0,1, 1,32'h3000,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,1,32'h200C,1,32'h4000,0,0,1, 1,32'h4000,0,0,0,0,0,1,1));
        tbl.push_back(rst_row);
        tbl.push_back(idle);
        tbl.push_back(idle);
        // counters back at 01
        tbl.push_back(mk(1,1,32'h104,0,32'h0,0,0,0, 0,0,0,0,0,0,0,0,0));
`ifdef BP_HYSTERESIS_EN
        tbl.push_back(mk(1,1,32'h104,1,32'h200,0,0,0, 1,32'h200,0,0,0,0,0,0,0));
`else
        tbl.push_back(mk(1,1,32'h104,1,32'h200,0,0,0, 1,32'h200,1,1,28'h10,30'h80,1,0,0));
`endif
        tbl.push_back(idle);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t e;
            nRST           = tbl[i].rst_n;
            resolve_valid  = tbl[i].v;
            resolve_pc     = tbl[i].pc;
            resolve_taken  = tbl[i].tk;
            resolve_target = tbl[i].tgt;
            pred_hit       = tbl[i].hit;
            pred_target    = tbl[i].pt;
            hold           = tbl[i].hold;
            exp_q.push_back(tbl[i]);
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            chk("mispredict", i, {31'd0, mispredict}, {31'd0, e.e_mis});
            if (e.e_mis || !e.rst_n)
                chk("correct_pc", i, correct_pc, e.e_cpc);
            chk("wen", i, {31'd0, wen}, {31'd0, e.e_wen});
            if (e.e_wen || !e.rst_n) begin
                chk("hash_wsel", i, {30'd0, hash_wsel}, {30'd0, e.e_hash});
                chk("tag_n", i, {4'd0, tag_n}, {4'd0, e.e_tag});
                chk("target_n", i, {2'd0, target_n}, {2'd0, e.e_tgt});
                chk("active_n", i, {31'd0, active_n}, {31'd0, e.e_act});
            end
            chk("full", i, {31'd0, full}, {31'd0, e.e_full});
            chk("overflow", i, {31'd0, overflow}, {31'd0, e.e_ov});
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_update_unit.md
# branch_update_unit

Resolves branch outcomes from execute against the fetch-time prediction and keeps the 4-entry branch target buffer trained. It sits directly downstream of the execute stage and upstream of the BTB write port. It produces a one-cycle mispredict/redirect pulse for the hazard unit, and drains queued BTB writes (index, tag, target, active) one per cycle.

## Interface
- DEPTH, 2, update-queue entries (power of two, ≥2)
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- resolve_valid  in  1  a resolved branch/jump is presented this cycle
- resolve_pc  in  32  PC of the branch; [1:0] ignored, hash = [3:2], tag = [31:4]
- resolve_taken  in  1  actual direction
- resolve_target  in  32  actual taken target; [1:0] ignored
- pred_hit  in  1  fetch saw a BTB hit, i.e. predicted taken
- pred_target  in  30  word target used by fetch when pred_hit
- hold  in  1  inhibits queue drain this cycle
- full  out  1  queue holds DEPTH entries (combinational from state)
- overflow  out  1  sticky: a resolve_valid arrived while full
- mispredict  out  1  registered one-cycle redirect pulse
- correct_pc  out  32  redirect PC, valid while mispredict=1
- wen  out  1  BTB write enable
- hash_wsel  out  2  BTB index
- tag_n  out  28  BTB tag = resolve_pc[31:4]
- target_n  out  30  BTB target = resolve_target[31:2]
- active_n  out  1  BTB entry valid bit to write

## Operation
- Mispredict when resolve_valid and (resolve_taken != pred_hit, or resolve_taken and pred_hit and resolve_target[31:2] != pred_target).
- correct_pc = resolve_taken ? {resolve_target[31:2],2'b00} : {resolve_pc[31:2],2'b00}+4.
- Mispredict evaluation is independent of queue state; a dropped update still reports its mispredict.
- Direction state: four 2-bit saturating counters, one per hash index, reset to 01 (weakly not-taken). On every accepted resolve: taken → increment (sat 11), not-taken → decrement (sat 00). Counters update at accept time, in program order, so back-to-back same-index branches see the already-updated value.
- Enqueue rule: accepted resolve enqueues {hash, tag, target, active} only if an update is needed: active = (new counter ≥ 10); needed when active != pred_hit, or active and target differs from pred_target.
- Not-needed resolves update the counter only.
- Accept = resolve_valid and not full. If full: no enqueue (even when a dequeue happens the same cycle), counter not updated, overflow set until reset.
- Drain: when queue non-empty and hold=0, head drives wen=1 with its fields and is popped on that edge. FIFO order; pointers wrap modulo DEPTH.
- Simultaneous enqueue and dequeue when not full: both occur; occupancy unchanged.

## Timing
- Reset (sync, nRST=0 at rising edge): queue empty, pointers 0, counters 01, overflow=0, mispredict=0, correct_pc=0, wen=0, hash_wsel=0, tag_n=0, target_n=0, active_n=0. Reset mid-drain discards all queued updates.
- mispredict/correct_pc: registered; resolve at edge N → pulse during cycle N+1, exactly one cycle per resolve.
- BTB write: wen, hash_wsel, tag_n, target_n, active_n are registered from queue head; resolve accepted at edge N → earliest wen=1 in cycle N+1 (empty queue, hold=0). The BTB captures on the following falling edge.
- hold=1 keeps wen=0; entries retained; full may assert.
- full reflects occupancy after the previous edge; upstream must not assert resolve_valid while full.

## Configuration
- BP_HYSTERESIS_EN defined: 2-bit saturating counters as above.
- Undefined: no counters; active = resolve_taken directly (last-outcome training); enqueue rule otherwise identical.

## Test plan
- Reset then resolve pc=0x0000_0104 taken target 0x0000_0200, pred_hit=0 → next cycle mispredict=1, correct_pc=0x200; counter[1] 01→10 → wen=1, hash_wsel=1, tag_n=0x0000010, target_n=0x80, active_n=1.
- Same branch resolved taken with pred_hit=1, pred_target=0x80 → mispredict=0, wen stays 0, counter[1]=11.
- Resolve not-taken at counter 11, pred_hit=1 → mispredict=1, correct_pc=0x108, no write (counter 10, still active); second not-taken → write active_n=0. Without BP_HYSTERESIS_EN the first not-taken writes active_n=0.
- hold=1, three needed resolves (DEPTH=2) → full=1 after two, third dropped, overflow=1, mispredicts still pulse; release hold → exactly two writes in FIFO order.
- Full queue, hold=0, resolve_valid → dequeue occurs, no enqueue, overflow=1.
- Assert nRST=0 with two queued entries → next cycle wen=0, full=0, counters 01, no stale write after release.
